// File: rtl/ov7670_capture_ctrl.sv
// OV7670 RGB565 capture: packs camera byte pairs into 16-bit pixels and
// issues frame-buffer writes with linear addresses, all in the PCLK domain.
module ov7670_capture_ctrl #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              frame_short,
  output logic              busy
);

  localparam int PIX_W  = $clog2(H_PIX + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [PIX_W-1:0]  LP_PIX_MAX   = PIX_W'(H_PIX);
  localparam logic [PIX_W-1:0]  LP_PIX_LAST  = PIX_W'(H_PIX - 1);
  localparam logic [LINE_W-1:0] LP_LINE_MAX  = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] LP_LINE_LAST = LINE_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LP_LINE_STEP = ADDR_W'(H_PIX);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_DONE} state_t;

  state_t              r_state;
  logic                r_vsync_d;
  logic                r_href_d;
  logic                r_phase;
  logic [7:0]          r_hi_byte;
  logic [PIX_W-1:0]    r_pix_cnt;
  logic [LINE_W-1:0]   r_line_cnt;
  logic [ADDR_W-1:0]   r_line_base;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [15:0]         r_wdata;
  logic                r_frame_done;
  logic                r_frame_short;
  logic                r_busy;

  logic w_vs_fall, w_vs_rise, w_href_fall, w_pix_ok, w_last_pix;

  assign w_vs_fall   = ~vsync & r_vsync_d;
  assign w_vs_rise   = vsync & ~r_vsync_d;
  assign w_href_fall = ~href & r_href_d;
  assign w_pix_ok    = (r_pix_cnt < LP_PIX_MAX) && (r_line_cnt < LP_LINE_MAX);
  assign w_last_pix  = (r_pix_cnt == LP_PIX_LAST) && (r_line_cnt == LP_LINE_LAST);

  assign we          = r_we;
  assign wAddr       = r_waddr;
  assign wData       = r_wdata;
  assign frame_done  = r_frame_done;
  assign frame_short = r_frame_short;
  assign busy        = r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_vsync_d     <= 1'b0;
      r_href_d      <= 1'b0;
      r_phase       <= 1'b0;
      r_hi_byte     <= '0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_base   <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_frame_done  <= 1'b0;
      r_frame_short <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_vsync_d     <= vsync;
      r_href_d      <= href;
      r_we          <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_short <= 1'b0;
      if (!capture_en) begin
        // Disarm overrides everything; any partial frame is silently dropped.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SYNC;
            r_busy  <= 1'b0;
          end
          S_SYNC: begin
            if (w_vs_fall) begin
              r_state     <= S_ACTIVE;
              r_busy      <= 1'b1;
              r_phase     <= 1'b0;
              r_pix_cnt   <= '0;
              r_line_cnt  <= '0;
              r_line_base <= '0;
            end
          end
          S_ACTIVE: begin
            if (w_vs_rise) begin
              r_state       <= S_SYNC;
              r_busy        <= 1'b0;
              r_frame_short <= 1'b1;
            end else if (href) begin
              if (!r_phase) begin
                r_hi_byte <= cam_data;
                r_phase   <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                // Pixels past the stored window are counted out, not written.
                if (w_pix_ok) begin
                  r_we      <= 1'b1;
                  r_wdata   <= {r_hi_byte, cam_data};
                  r_waddr   <= r_line_base + ADDR_W'(r_pix_cnt);
                  r_pix_cnt <= r_pix_cnt + 1'b1;
                  if (w_last_pix) begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_DONE;
                  end
                end
              end
            end else if (w_href_fall) begin
              r_phase <= 1'b0;
              if (r_pix_cnt != '0) begin
                r_line_cnt  <= r_line_cnt + 1'b1;
                r_line_base <= r_line_base + LP_LINE_STEP;
                r_pix_cnt   <= '0;
              end
            end
          end
          S_DONE: begin
            r_busy <= 1'b0;
            if (w_vs_rise) r_state <= S_SYNC;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench: a 4x2 instance for frame-level sequences and a default
// 320x240 instance for line overflow and odd-byte handling.
module tb_ov7670_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        capture_en;
  logic        vsync;
  logic        href;
  logic [7:0]  cam_data;

  logic        we_s, fd_s, fs_s, busy_s;
  logic [16:0] wAddr_s;
  logic [15:0] wData_s;
  logic        we_d, fd_d, fs_d, busy_d;
  logic [16:0] wAddr_d;
  logic [15:0] wData_d;

  int n_vec = 0;
  int n_err = 0;

  logic        mon_en = 1'b0;
  logic [32:0] wq[$];

  always #5 clk = ~clk;

  ov7670_capture_ctrl #(.H_PIX(4), .V_LINES(2), .ADDR_W(17)) dut_s (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .vsync(vsync),
    .href(href), .cam_data(cam_data), .we(we_s), .wAddr(wAddr_s),
    .wData(wData_s), .frame_done(fd_s), .frame_short(fs_s), .busy(busy_s));

  ov7670_capture_ctrl dut_d (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .vsync(vsync),
    .href(href), .cam_data(cam_data), .we(we_d), .wAddr(wAddr_d),
    .wData(wData_d), .frame_done(fd_d), .frame_short(fs_d), .busy(busy_d));

  always @(negedge clk) if (mon_en && we_d) wq.push_back({wAddr_d, wData_d});

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [16:0] addr;
    logic [15:0] data;
    logic        done;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_pix(input logic [7:0] h, input logic [7:0] l);
    href = 1'b1; cam_data = h; tick();
    cam_data = l; tick();
  endtask

  task automatic line_end();
    href = 1'b0; tick(); tick();
  endtask

  task automatic new_frame();
    href = 1'b0; vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  initial begin
    vec_t tv[8];
    logic [16:0] ea;
    logic [15:0] ed;
    logic [7:0]  b0, b1;
    tv[0] = '{8'h01, 8'h02, 17'd0, 16'h0102, 1'b0};
    tv[1] = '{8'h03, 8'h04, 17'd1, 16'h0304, 1'b0};
    tv[2] = '{8'h05, 8'h06, 17'd2, 16'h0506, 1'b0};
    tv[3] = '{8'h07, 8'h08, 17'd3, 16'h0708, 1'b0};
    tv[4] = '{8'h11, 8'h12, 17'd4, 16'h1112, 1'b0};
    tv[5] = '{8'h13, 8'h14, 17'd5, 16'h1314, 1'b0};
    tv[6] = '{8'h15, 8'h16, 17'd6, 16'h1516, 1'b0};
    tv[7] = '{8'h17, 8'h18, 17'd7, 16'h1718, 1'b1};

    reset_n = 1'b0; capture_en = 1'b0; vsync = 1'b1; href = 1'b0; cam_data = 8'h00;
    tick(); tick();
    chk("rst_we",   32'(we_s),    32'd0);
    chk("rst_addr", 32'(wAddr_s), 32'd0);
    chk("rst_data", 32'(wData_s), 32'd0);
    chk("rst_busy", 32'(busy_s),  32'd0);
    chk("rst_fd",   32'(fd_s),    32'd0);
    chk("rst_fs",   32'(fs_s),    32'd0);

    reset_n = 1'b1; tick(); tick();
    capture_en = 1'b1; tick();
    vsync = 1'b0; tick();
    chk("arm_busy", 32'(busy_s), 32'd1);

    for (int i = 0; i < 8; i++) begin
      if (i == 4) line_end();
      send_pix(tv[i].hi, tv[i].lo);
      chk($sformatf("v%0d_we", i),   32'(we_s),    32'd1);
      chk($sformatf("v%0d_addr", i), 32'(wAddr_s), 32'(tv[i].addr));
      chk($sformatf("v%0d_data", i), 32'(wData_s), 32'(tv[i].data));
      chk($sformatf("v%0d_fd", i),   32'(fd_s),    32'(tv[i].done));
      chk($sformatf("v%0d_busy", i), 32'(busy_s),  32'(!tv[i].done));
    end
    send_pix(8'h55, 8'h66);
    chk("done_no_we", 32'(we_s), 32'd0);
    chk("done_hold_addr", 32'(wAddr_s), 32'd7);
    chk("done_fd_low", 32'(fd_s), 32'd0);

    // Default instance: odd-length line, overlong line, then one pixel.
    href = 1'b0; vsync = 1'b1; tick();
    chk("d_short", 32'(fs_d), 32'd1);
    chk("s_no_short", 32'(fs_s), 32'd0);
    tick();
    vsync = 1'b0; tick();
    chk("d_busy", 32'(busy_d), 32'd1);
    mon_en = 1'b1;
    for (int k = 0; k < 641; k++) begin
      href = 1'b1; cam_data = 8'(k); tick();
    end
    line_end();
    for (int k = 0; k < 660; k++) begin
      href = 1'b1; cam_data = 8'(k + 64); tick();
    end
    line_end();
    send_pix(8'hAB, 8'hCD);
    line_end();
    mon_en = 1'b0;
    chk("d_wcount", 32'(wq.size()), 32'd641);
    for (int p = 0; p < wq.size() && p < 641; p++) begin
      if (p < 320) begin
        ea = 17'(p); b0 = 8'(2 * p); b1 = 8'(2 * p + 1); ed = {b0, b1};
      end else if (p < 640) begin
        ea = 17'(p); b0 = 8'(2 * (p - 320) + 64); b1 = 8'(2 * (p - 320) + 65); ed = {b0, b1};
      end else begin
        ea = 17'd640; ed = 16'hABCD;
      end
      chk($sformatf("d_w%0d", p), 32'(wq[p]), {15'd0, ea} ^ 32'd0 ? 32'({ea, ed}) : 32'({ea, ed}));
    end

    // Aborted frame on the small instance.
    new_frame();
    for (int i = 0; i < 4; i++) send_pix(tv[i].hi, tv[i].lo);
    line_end();
    vsync = 1'b1; tick();
    chk("ab_short", 32'(fs_s), 32'd1);
    chk("ab_fd", 32'(fd_s), 32'd0);
    chk("ab_we", 32'(we_s), 32'd0);
    tick();
    chk("ab_short_once", 32'(fs_s), 32'd0);
    vsync = 1'b0; tick();
    send_pix(8'hA1, 8'hA2);
    chk("ab_re_we", 32'(we_s), 32'd1);
    chk("ab_re_addr", 32'(wAddr_s), 32'd0);
    chk("ab_re_data", 32'(wData_s), 32'hA1A2);

    // capture_en dropped mid-frame.
    capture_en = 1'b0; href = 1'b1; cam_data = 8'hB1; tick();
    chk("dis_busy", 32'(busy_s), 32'd0);
    cam_data = 8'hB2; tick();
    chk("dis_we", 32'(we_s), 32'd0);
    chk("dis_fs", 32'(fs_s), 32'd0);
    capture_en = 1'b1; tick();
    send_pix(8'hC1, 8'hC2);
    chk("dis_wait_we", 32'(we_s), 32'd0);
    chk("dis_wait_busy", 32'(busy_s), 32'd0);
    line_end();
    new_frame();
    chk("dis_rearm_busy", 32'(busy_s), 32'd1);
    send_pix(8'hD1, 8'hD2);
    chk("dis_re_we", 32'(we_s), 32'd1);
    chk("dis_re_addr", 32'(wAddr_s), 32'd0);
    chk("dis_re_data", 32'(wData_s), 32'hD1D2);

    // Asynchronous reset while we is high.
    send_pix(8'hE1, 8'hE2);
    chk("ar_pre_we", 32'(we_s), 32'd1);
    chk("ar_pre_addr", 32'(wAddr_s), 32'd1);
    reset_n = 1'b0; #1;
    chk("ar_we", 32'(we_s), 32'd0);
    chk("ar_addr", 32'(wAddr_s), 32'd0);
    chk("ar_fd", 32'(fd_s), 32'd0);
    chk("ar_busy", 32'(busy_s), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    send_pix(8'hF1, 8'hF2);
    chk("ar_wait_we", 32'(we_s), 32'd0);
    line_end();
    new_frame();
    send_pix(8'h12, 8'h34);
    chk("ar_re_we", 32'(we_s), 32'd1);
    chk("ar_re_addr", 32'(wAddr_s), 32'd0);
    chk("ar_re_data", 32'(wData_s), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_ctrl.md
Name: ov7670_capture_ctrl

Overview:
- Upstream stage of the QVGA frame buffer.
- Samples the OV7670 8-bit parallel stream (RGB565, two bytes per pixel) and packs each byte pair into one 16-bit pixel.
- Produces write strobes and linear addresses (line*H_PIX + pixel) into the 320x240 dual-port frame buffer. The QVGA read-side memory controller consumes that buffer.
- Runs entirely in the camera pixel-clock domain.

Parameters:
- H_PIX, 320, pixels per line stored; pixels beyond this in a line are discarded.
- V_LINES, 240, lines per frame stored; lines beyond this are discarded.
- ADDR_W, 17, write-address width; must satisfy 2^ADDR_W >= H_PIX*V_LINES.

Ports:
- clk, input, 1: camera PCLK. All inputs are sampled on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- capture_en, input, 1: when high, the block arms on the next frame; when low, the block finishes nothing and returns to IDLE.
- vsync, input, 1: camera VSYNC, active-high, high between frames.
- href, input, 1: camera HREF, high while line bytes are valid.
- cam_data, input, 8: camera D[7:0].
- we, output, 1: frame-buffer write enable, one-cycle pulse per pixel.
- wAddr, output, ADDR_W: frame-buffer write address.
- wData, output, 16: pixel; first byte in [15:8], second byte in [7:0].
- frame_done, output, 1: one-cycle pulse coincident with the write of the last address, H_PIX*V_LINES-1.
- frame_short, output, 1: one-cycle pulse when a frame is aborted by vsync before completion.
- busy, output, 1: high in ACTIVE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, and every output is 0.
  - Internal counters, byte phase and vsync_d are all cleared to 0.
- Edge detection:
  - vsync_d and href_d are registered copies of the inputs.
  - vs_fall = ~vsync & vsync_d; vs_rise = vsync & ~vsync_d; href_fall = ~href & href_d.
- FSM states and transitions:
  - IDLE -> SYNC when capture_en=1.
  - SYNC -> ACTIVE on vs_fall. On entry, pix_cnt=0, line_cnt=0, phase=0, addr=0.
  - ACTIVE -> DONE after the write of the final pixel. That write has frame_done=1 and busy=0 in the same cycle.
  - ACTIVE -> SYNC on vs_rise before completion. frame_short pulses for 1 cycle on the cycle after the edge; no write occurs.
  - DONE -> SYNC on vs_rise. Data is ignored while in DONE.
  - Any state -> IDLE when capture_en=0. The transition is registered and takes effect on the next edge. A partial frame is abandoned with no frame_short pulse.
- Pixel packing in ACTIVE with href=1:
  - phase=0: latch cam_data into hi_byte, then phase=1.
  - phase=1: a pixel is complete, then phase=0.
- Write of a completed pixel (only if pix_cnt < H_PIX and line_cnt < V_LINES):
  - On the edge that samples byte 2, the registers load we=1, wData={hi_byte, cam_data}, wAddr=line_cnt*H_PIX+pix_cnt.
  - we is therefore high for exactly the one cycle after that edge; latency from byte 2 on the bus to we=1 is 1 cycle.
  - pix_cnt saturates at H_PIX; overflow pixels are dropped silently.
  - wAddr is maintained incrementally with a line-base register (line_base += H_PIX per line). No multiplier is used.
- Line end (href_fall in ACTIVE):
  - phase=0; a dangling odd byte is discarded.
  - If pix_cnt>0: line_cnt++, line_base += H_PIX, pix_cnt=0.
  - Lines beyond V_LINES produce no writes.
- Simultaneous events:
  - vs_rise has priority over href data in the same cycle.
  - capture_en=0 has priority over all other events.
- wAddr and wData hold their last value while we=0.
- Reset mid-frame: all outputs go to 0 immediately. After release the block re-arms from IDLE and waits for a full vs_fall.

Test Plan:
- reset_n=0 mid-line with we=1 -> we, wAddr, frame_done and busy read 0 asynchronously, before the next clk edge; after release, no write until capture_en=1 and a vs_fall.
- H_PIX=4, V_LINES=2; vs_fall then 2 lines of 8 bytes 0x01..0x08 and 0x11..0x18 -> 8 writes at wAddr 0..7 with wData 0x0102, 0x0304, 0x0506, 0x0708, 0x1112, …, 0x1718; frame_done coincides with wAddr=7; state then DONE.
- Default params; one line of 641 bytes (odd count, 320 full pixels plus 1 extra byte) -> 320 writes at wAddr 0..319; the extra byte is dropped; the next line starts at wAddr 320.
- Default params; 330 pixels in one line -> only 320 writes, with the last wAddr=319; the next line begins at 320.
- H_PIX=4, V_LINES=2; vs_rise after line 1 -> frame_short pulses once, frame_done stays 0; the next vs_fall restarts at wAddr 0.
- capture_en drops mid-frame -> busy=0 the next cycle, no further we, no frame_short; re-enabling waits for a fresh vs_fall.
